// File: rtl/gray_cnt.sv
// Registered up/down Gray-code counter with a 1-deep valid/ready output stage.
// Binary and Gray codes are both registered, so gray_out never glitches.
module gray_cnt #(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  output logic             tc
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             tc_q, tc_d;
  logic             accept, step, at_limit;

  assign accept   = valid_q & out_ready;
  assign step     = en & ~load & (~valid_q | out_ready);
  assign at_limit = up ? (bin_q == {WIDTH{1'b1}}) : (bin_q == {WIDTH{1'b0}});

  always_comb begin
    bin_d   = bin_q;
    valid_d = valid_q & ~accept;
    tc_d    = 1'b0;
    if (load) begin
      // Load overrides backpressure; an unaccepted code is dropped.
      bin_d   = load_val;
      valid_d = 1'b1;
    end else if (step) begin
      if (at_limit) begin
        tc_d = 1'b1;
        if (WRAP) begin
          bin_d   = up ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
          valid_d = 1'b1;
        end
      end else begin
        bin_d   = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        valid_d = 1'b1;
      end
    end
  end

  assign gray_d = bin_d ^ (bin_d >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      tc_q    <= tc_d;
    end
  end

  assign bin_out   = bin_q;
  assign gray_out  = gray_q;
  assign out_valid = valid_q;
  assign tc        = tc_q;

endmodule

// File: tb/tb_gray_cnt.sv
// Directed bench for gray_cnt: a wrapping and a saturating instance share one stimulus.
module tb_gray_cnt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0, out_ready = 1'b1;
  logic [3:0] load_val = 4'h0;

  logic [3:0] gray_w, bin_w, gray_s, bin_s;
  logic       valid_w, tc_w, valid_s, tc_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_cnt #(.WIDTH(4), .WRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .out_ready(out_ready), .gray_out(gray_w), .bin_out(bin_w), .out_valid(valid_w), .tc(tc_w)
  );

  gray_cnt #(.WIDTH(4), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .out_ready(out_ready), .gray_out(gray_s), .bin_out(bin_s), .out_valid(valid_s), .tc(tc_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [3:0] gexp[5];
  logic [3:0] exp_bin;

  initial begin
    gexp[0] = 4'b0001; gexp[1] = 4'b0011; gexp[2] = 4'b0010;
    gexp[3] = 4'b0110; gexp[4] = 4'b0111;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bin", bin_w, 0);
    chk("rst_gray", gray_w, 0);
    chk("rst_valid", valid_w, 0);
    chk("rst_tc", tc_w, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Free-running up count
    en = 1'b1; up = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("up_gray", gray_w, gexp[i]);
      chk("up_bin", bin_w, i + 1);
      chk("up_valid", valid_w, 1);
      chk("up_tc", tc_w, 0);
    end

    // Load all-ones then wrap upward
    en = 1'b0; load = 1'b1; load_val = 4'hF;
    tick();
    chk("ld_bin", bin_w, 4'hF);
    chk("ld_gray", gray_w, 4'b1000);
    chk("ld_tc", tc_w, 0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("wrap_up_bin", bin_w, 0);
    chk("wrap_up_gray", gray_w, 0);
    chk("wrap_up_tc", tc_w, 1);
    chk("wrap_up_valid", valid_w, 1);
    chk("sat_up_bin", bin_s, 4'hF);
    chk("sat_up_tc", tc_s, 1);
    chk("sat_up_valid", valid_s, 0);
    en = 1'b0;
    tick();
    chk("tc_pulse_end", tc_w, 0);
    chk("accepted_valid", valid_w, 0);
    en = 1'b1; up = 1'b0;
    tick();
    chk("wrap_dn_bin", bin_w, 4'hF);
    chk("wrap_dn_gray", gray_w, 4'b1000);
    chk("wrap_dn_tc", tc_w, 1);
    en = 1'b0;

    // Backpressure stall from 0
    load = 1'b1; load_val = 4'h0;
    tick();
    load = 1'b0;
    tick();
    chk("drain_valid", valid_w, 0);
    out_ready = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("stall_first_gray", gray_w, 4'b0001);
    chk("stall_first_valid", valid_w, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_gray", gray_w, 4'b0001);
      chk("stall_valid", valid_w, 1);
    end
    out_ready = 1'b1;
    tick();
    chk("resume_gray", gray_w, 4'b0011);
    chk("resume_bin", bin_w, 2);

    // Load beats en and backpressure
    out_ready = 1'b0; load = 1'b1; load_val = 4'hD;
    tick();
    chk("ld_bp_gray", gray_w, 4'b1011);
    chk("ld_bp_valid", valid_w, 1);
    chk("ld_bp_tc", tc_w, 0);

    // Saturation at both ends
    out_ready = 1'b1; en = 1'b0; load_val = 4'hF;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("sat_hi_bin", bin_s, 4'hF);
    chk("sat_hi_tc", tc_s, 1);
    en = 1'b0; load = 1'b1; load_val = 4'h0;
    tick();
    chk("sat_lo_ld_tc", tc_s, 0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    chk("sat_lo_bin", bin_s, 0);
    chk("sat_lo_gray", gray_s, 0);
    chk("sat_lo_tc", tc_s, 1);

    // Reset mid-count, between edges
    up = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bin", bin_w, 0);
    chk("mid_rst_gray", gray_w, 0);
    chk("mid_rst_valid", valid_w, 0);
    chk("mid_rst_tc", tc_w, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_gray", gray_w, 4'b0001);
    chk("restart_bin", bin_w, 1);

    // Full sweep through a gray-to-binary decode
    exp_bin = 4'h1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_bin = exp_bin + 4'h1;
      chk("sweep_bin", bin_w, exp_bin);
      chk("sweep_gray", gray_w, exp_bin ^ (exp_bin >> 1));
      chk("sweep_decode", g2b(gray_w), exp_bin);
      chk("sweep_tc", tc_w, (exp_bin == 4'h0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
